demux_1to2_buffered: RTL and testbench

Registered 1-to-2 demultiplexer: the receiving end of the 2:1 mux path. It accepts one word per handshake from a single input stream and routes it to one of two output lanes. The lane is chosen either by an explicit select bit or by automatic alternation. Each lane holds one word in its own buffer with a valid/ready handshake and keeps a wrapping count of delivered words. It sits after a time-multiplexed link and reconstructs the two original streams.

---
 rtl/demux_defs.sv | 18 +
 rtl/demux_lane.sv | 80 ++++++++
 rtl/demux_1to2_buffered.sv | 90 +++++++++
 tb/tb_demux_1to2_buffered.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_defs.sv
// rtl/demux_defs.sv - shared constants and types for the buffered 1-to-2 demultiplexer
package demux_defs;

    // Default data and counter widths
    localparam int WIDTH_DEF = 8;
    localparam int CNTW_DEF  = 8;

    // Lane index constants
    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    // Per-lane buffer state: a lane holds at most one word
    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_t;

endpackage

// File: rtl/demux_lane.sv
// rtl/demux_lane.sv - one-entry output lane buffer with valid/ready handshake and delivery counter
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   load       write load_data into the buffer at the next edge
//   load_data  word to store
//   ready      downstream consumes the buffered word this cycle
//   data       buffer contents (holds last word after drain)
//   valid      buffer holds an undelivered word
//   cnt        wrapping count of delivered words (valid && ready)
//   full       buffer occupied and not draining this cycle
module demux_lane
    import demux_defs::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNTW  = CNTW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic [CNTW-1:0]  cnt,
    output logic             full
);

    lane_state_t state;
    lane_state_t state_next;
    logic        deliver;

    assign valid   = (state == LANE_FULL);
    assign deliver = valid && ready;
    // A lane being drained this cycle can take a new word at the same edge
    assign full    = valid && !ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LANE_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LANE_EMPTY: begin
                if (load) begin
                    state_next = LANE_FULL;
                end
            end
            LANE_FULL: begin
                // drain+load keeps the lane full with the new word
                if (deliver && !load) begin
                    state_next = LANE_EMPTY;
                end
            end
            default: state_next = LANE_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (deliver) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/demux_1to2_buffered.sv
// rtl/demux_1to2_buffered.sv - registered 1-to-2 demultiplexer with explicit or alternating lane selection
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_data, in_sel          word to route and its destination lane (alt_mode=0)
//   in_valid, in_ready       input handshake; in_ready is combinational
//   alt_mode                 1 = ignore in_sel and alternate lanes starting at lane 0
//   out0_*, out1_*           lane buffers with valid/ready handshake
//   cnt0, cnt1               wrapping delivered-word counters per lane
//   ptr                      lane the next word goes to in alt_mode
module demux_1to2_buffered
    import demux_defs::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNTW  = CNTW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             alt_mode,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNTW-1:0]  cnt0,
    output logic [CNTW-1:0]  cnt1,
    output logic             ptr
);

    logic dst;
    logic full0;
    logic full1;
    logic accept;
    logic load0;
    logic load1;

    assign dst = alt_mode ? ptr : in_sel;

    // Only the destination lane's occupancy gates the input; in_valid is not used here
    assign in_ready = (dst == LANE1) ? !full1 : !full0;
    assign accept   = in_valid && in_ready;
    assign load0    = accept && (dst == LANE0);
    assign load1    = accept && (dst == LANE1);

    // The pointer advances only on accepted words in alt mode and otherwise holds,
    // so toggling alt_mode resumes alternation where it left off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= LANE0;
        end else if (accept && alt_mode) begin
            ptr <= ~ptr;
        end
    end

    demux_lane #(
        .WIDTH (WIDTH),
        .CNTW  (CNTW)
    ) u_lane0 (
        .clk       (clk),
        .rst       (rst),
        .load      (load0),
        .load_data (in_data),
        .ready     (out0_ready),
        .data      (out0_data),
        .valid     (out0_valid),
        .cnt       (cnt0),
        .full      (full0)
    );

    demux_lane #(
        .WIDTH (WIDTH),
        .CNTW  (CNTW)
    ) u_lane1 (
        .clk       (clk),
        .rst       (rst),
        .load      (load1),
        .load_data (in_data),
        .ready     (out1_ready),
        .data      (out1_data),
        .valid     (out1_valid),
        .cnt       (cnt1),
        .full      (full1)
    );

endmodule

// File: tb/tb_demux_1to2_buffered.sv
// tb/tb_demux_1to2_buffered.sv - self-checking bench for demux_1to2_buffered
module tb_demux_1to2_buffered;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_sel;
    logic       in_valid;
    logic       in_ready;
    logic       alt_mode;
    logic [7:0] out0_data;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out1_data;
    logic       out1_valid;
    logic       out1_ready;
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic       ptr;

    demux_1to2_buffered #(.WIDTH(8), .CNTW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alt_mode   (alt_mode),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1),
        .ptr        (ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       alt;
        logic       sel;
        logic       valid;
        logic [7:0] data;
        logic       r0;
        logic       r1;
        logic       exp_ready;
    } vec_t;

    vec_t vecs[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the two lanes and the pointer
    logic       mv0, mv1, mp;
    logic [7:0] md0, md1, mc0, mc1;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mv0 = 0; mv1 = 0; mp = 0;
        md0 = 0; md1 = 0; mc0 = 0; mc1 = 0;
        q0.delete();
        q1.delete();
    endtask

    task automatic check_state();
        chk("out0_valid", out0_valid, mv0);
        chk("out1_valid", out1_valid, mv1);
        chk("out0_data", out0_data, md0);
        chk("out1_data", out1_data, md1);
        chk("cnt0", cnt0, mc0);
        chk("cnt1", cnt1, mc1);
        chk("ptr", ptr, mp);
    endtask

    task automatic step(input logic alt, input logic sel, input logic valid, input logic [7:0] data,
                        input logic r0, input logic r1, input logic use_exp, input logic exp_ready);
        logic       dst, rdy, acc;
        logic [7:0] e;
        @(negedge clk);
        alt_mode = alt; in_sel = sel; in_valid = valid; in_data = data;
        out0_ready = r0; out1_ready = r1;
        #1;
        dst = alt ? mp : sel;
        rdy = dst ? !(mv1 && !r1) : !(mv0 && !r0);
        acc = valid && rdy;
        chk("in_ready", in_ready, rdy);
        if (use_exp) chk("in_ready_table", in_ready, exp_ready);
        check_state();
        // Scoreboard: every delivery must present the oldest word pushed for that lane
        if (mv0 && r0) begin
            if (q0.size() == 0) chk("sb0_underflow", 1, 0);
            else begin e = q0.pop_front(); chk("sb0_word", out0_data, e); end
        end
        if (mv1 && r1) begin
            if (q1.size() == 0) chk("sb1_underflow", 1, 0);
            else begin e = q1.pop_front(); chk("sb1_word", out1_data, e); end
        end
        @(posedge clk);
        if (mv0 && r0) begin mc0 = mc0 + 8'd1; mv0 = 0; end
        if (mv1 && r1) begin mc1 = mc1 + 8'd1; mv1 = 0; end
        if (acc && !dst) begin mv0 = 1; md0 = data; q0.push_back(data); end
        if (acc && dst)  begin mv1 = 1; md1 = data; q1.push_back(data); end
        if (acc && alt) mp = ~mp;
    endtask

    function automatic vec_t mk(input logic alt, input logic sel, input logic valid, input logic [7:0] data,
                                input logic r0, input logic r1, input logic exp_ready);
        vec_t v;
        v.alt = alt; v.sel = sel; v.valid = valid; v.data = data;
        v.r0 = r0; v.r1 = r1; v.exp_ready = exp_ready;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] c0_start, c1_start, d;

        // explicit routing
        vecs.push_back(mk(0, 0, 1, 8'hA5, 1, 1, 1));
        vecs.push_back(mk(0, 1, 1, 8'h3C, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1));
        // alternation
        vecs.push_back(mk(1, 1, 1, 8'h01, 1, 1, 1));
        vecs.push_back(mk(1, 1, 1, 8'h02, 1, 1, 1));
        vecs.push_back(mk(1, 0, 1, 8'h03, 1, 1, 1));
        vecs.push_back(mk(1, 0, 1, 8'h04, 1, 1, 1));
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 1, 1));
        // backpressure then drain+load
        vecs.push_back(mk(0, 0, 1, 8'h11, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 8'h22, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 8'h22, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1));
        // alt-mode stall with lane0 full and lane1 empty
        vecs.push_back(mk(1, 0, 1, 8'h55, 0, 1, 1));
        vecs.push_back(mk(1, 0, 1, 8'h66, 0, 1, 1));
        vecs.push_back(mk(1, 0, 1, 8'h77, 0, 1, 0));
        vecs.push_back(mk(1, 1, 1, 8'h77, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 8'h77, 1, 1, 1));
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 1, 1));
        // alt_mode off with ptr=1 held, then resume
        vecs.push_back(mk(0, 0, 1, 8'h88, 1, 1, 1));
        vecs.push_back(mk(1, 0, 1, 8'h99, 1, 1, 1));
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 1, 1));

        rst = 1; in_data = 0; in_sel = 0; in_valid = 0; alt_mode = 0;
        out0_ready = 0; out1_ready = 0;
        model_reset();
        #2;
        check_state();
        chk("in_ready_in_reset", in_ready, 1);
        @(negedge clk);
        rst = 0;

        foreach (vecs[i])
            step(vecs[i].alt, vecs[i].sel, vecs[i].valid, vecs[i].data, vecs[i].r0, vecs[i].r1, 1, vecs[i].exp_ready);

        // counter wrap: 256 lane1 deliveries
        c0_start = mc0;
        c1_start = mc1;
        for (int i = 0; i < 256; i++) begin
            d = i[7:0];
            step(0, 1, 1, d, 1, 1, 1, 1);
        end
        step(0, 1, 0, 8'h00, 1, 1, 1, 1);
        #2;
        chk("cnt1_wrap", cnt1, c1_start);
        chk("cnt0_unchanged", cnt0, c0_start);

        // mid-operation reset with both lanes full
        step(0, 0, 1, 8'h81, 0, 0, 1, 1);
        step(0, 1, 1, 8'h82, 0, 0, 1, 1);
        step(1, 0, 1, 8'hC3, 0, 0, 0, 0);
        @(negedge clk);
        in_valid = 0; out0_ready = 0; out1_ready = 0; alt_mode = 0;
        chk("pre_reset_out0_valid", out0_valid, 1);
        chk("pre_reset_out1_valid", out1_valid, 1);
        #2;
        rst = 1;
        #1;
        model_reset();
        check_state();
        chk("in_ready_after_reset", in_ready, 1);
        @(negedge clk);
        rst = 0;

        // first accept after reset release
        step(0, 0, 1, 8'h9A, 1, 1, 1, 1);
        step(0, 1, 1, 8'h5B, 1, 1, 1, 1);
        step(0, 0, 0, 8'h00, 1, 1, 1, 1);
        step(0, 0, 0, 8'h00, 1, 1, 1, 1);
        chk("sb0_drained", q0.size(), 0);
        chk("sb1_drained", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
